load_store_unit: RTL

Initiator-side load/store unit that converts core byte-addressed memory requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the single-port data memory interface. The data memory has a combinational read and a synchronous write, and is indexed by word. The unit sits between the execute stage and the data memory. It performs read-modify-write for sub-word stores, formats and extends load data, and flags misaligned and out-of-range accesses. A valid/ready handshake on both the request and response sides allows the core to stall.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte-addressed loads/stores into word
// accesses on a single-port memory (combinational read, sync write).
// Ports:
//   CLK, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_we, req_funct3,
//                       req_addr, req_wdata carry the request
//   rsp_valid/ready     response handshake; rsp_rdata, rsp_err
//   mem_WE, mem_A       write enable, word index (addr >> 2)
//   mem_WD, mem_RD      write data, combinational read data
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WRITE, DONE
  } state_t;

  state_t      state, state_nx;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;

  logic        f3_bad, misal, oor, req_err;
  logic [31:0] merged, ld;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Request check uses the live inputs so the error is known on accept.
  always_comb begin
    f3_bad = (req_funct3 == 3'b011) ||
             (req_funct3[2:1] == 2'b11) ||
             (req_we && req_funct3[2]);
    misal  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
             ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    oor    = (req_addr >> (WORD_ADDR_BITS + 2)) != 32'd0;
    req_err = f3_bad || misal || oor;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = req_err ? DONE : ACCESS;
      end
      ACCESS: state_nx = we_q ? WRITE : DONE;
      WRITE:  state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS)
        word_q <= mem_RD;
    end
  end

  assign b_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign h_sel = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    merged = word_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    ld = 32'd0;
    case (f3_q)
      3'b000:  ld = {{24{b_sel[7]}}, b_sel};
      3'b001:  ld = {{16{h_sel[15]}}, h_sel};
      3'b010:  ld = word_q;
      3'b100:  ld = {24'd0, b_sel};
      3'b101:  ld = {16'd0, h_sel};
      default: ld = 32'd0;
    endcase
  end

  assign rsp_rdata = (state == DONE && !err_q && !we_q) ? ld : 32'd0;
  assign rsp_err   = (state == DONE) && err_q;
  assign mem_A     = {2'b00, addr_q[31:2]};
  assign mem_WD    = merged;
  // Gated by rst so a reset landing on WRITE never reaches memory.
  assign mem_WE    = (state == WRITE) && !rst;

endmodule
